fp_mant_normalizer: RTL and testbench

Post-add normalization stage of the FP adder/subtractor. The alignment path right-shifts the smaller operand before the add; this block does the opposite after the add. It takes the raw mantissa sum and left-shifts it by the leading-zero count, or right-shifts it by 1 on carry-out, and adjusts the exponent to match. It clamps to denormal when the exponent would go below 1 and flags zero and overflow. It is a 2-stage valid/ready pipeline between the mantissa adder and the rounding block.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_lzc.sv | 35 +++
 rtl/fp_mant_normalizer.sv | 203 ++++++++++++++++++++
 tb/tb_fp_mant_normalizer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the FP adder/subtractor datapath.
//   MANT_W  : raw mantissa sum width (carry, hidden, 23 fraction, G, R, S)
//   EXP_W   : biased exponent width
//   LZC_W   : leading-zero count / shift amount width (2**LZC_W >= MANT_W-1)
//   EXP_MAX : all-ones exponent (infinity encoding)
//   stage_payload_t : {sign, exp, normalized mantissa} carried between stages
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int MANT_W = 28;
    localparam int EXP_W  = 8;
    localparam int LZC_W  = 5;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                sign;
        logic [EXP_W-1:0]    exp;
        logic [MANT_W-2:0]   mant;
    } stage_payload_t;

endpackage

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter. Counts zeros from the MSB of data down
// to the first set bit; an all-zero input saturates the count at W.
// Ports:
//   data  in  W   value to scan
//   lzc   out CW  number of leading zeros (W when data == 0)
// -----------------------------------------------------------------------------
module fp_lzc
    import fp_pkg::*;
#(
    parameter int W  = MANT_W - 1,
    parameter int CW = LZC_W
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] lzc
);

    logic found;

    // Priority scan from the MSB; the first set bit fixes the count.
    always_comb begin
        lzc   = CW'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && data[i]) begin
                lzc   = CW'(W - 1 - i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/fp_mant_normalizer.sv
// -----------------------------------------------------------------------------
// fp_mant_normalizer
// Post-add normalization for the FP adder/subtractor. Stage 1 captures the sum
// and its leading-zero count; stage 2 selects carry / zero / normal / denormal
// handling, shifts the mantissa and adjusts the exponent. Two-entry
// valid/ready pipeline, one result per cycle, 2-cycle latency.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready depends combinationally on out_ready)
//   in_sign           sign of the sum, passed through
//   in_exp [EXP_W]    biased exponent of the larger operand
//   in_mant[MANT_W]   raw mantissa sum {carry, hidden, frac, G, R, S}
//   out_valid/out_ready output handshake
//   out_sign, out_exp[EXP_W], out_mant[MANT_W-1]  normalized result
//   out_zero          result mantissa is zero
//   out_ovf           exponent overflowed to all-ones
// -----------------------------------------------------------------------------
module fp_mant_normalizer
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-2:0] out_mant,
    output logic              out_zero,
    output logic              out_ovf
);

    localparam logic [EXP_W:0] EXP_MAX_X = {1'b0, EXP_MAX};
    localparam logic [EXP_W:0] EXP_ONE_X = {{EXP_W{1'b0}}, 1'b1};

    // stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]  s1_eeff_q,  s1_eeff_d;
    logic              s1_carry_q, s1_carry_d;
    logic [MANT_W-2:0] s1_m_q,     s1_m_d;
    logic [LZC_W-1:0]  s1_lzc_q,   s1_lzc_d;
    logic [MANT_W-2:0] s1_mr_q,    s1_mr_d;

    // stage 2 (output) state
    logic              s2_valid_q, s2_valid_d;
    stage_payload_t    out_pl_q,   out_pl_d;
    logic              out_zero_q, out_zero_d;
    logic              out_ovf_q,  out_ovf_d;

    logic              s1_advance;
    logic              in_xfer;
    logic [EXP_W-1:0]  e_eff;
    logic [LZC_W-1:0]  m_lzc;

    stage_payload_t    res_pl;
    logic              res_zero;
    logic              res_ovf;
    logic [EXP_W:0]    exp_inc;
    logic [EXP_W:0]    eeff_x;
    logic [EXP_W:0]    lzc_x;
    logic [LZC_W-1:0]  clamp_sh;

    fp_lzc #(
        .W  (MANT_W - 1),
        .CW (LZC_W)
    ) u_lzc (
        .data (in_mant[MANT_W-2:0]),
        .lzc  (m_lzc)
    );

    // Handshake: stage 1 may refill in the same cycle it hands off to stage 2.
    always_comb begin
        s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready   = !s1_valid_q || s1_advance;
        in_xfer    = in_valid && in_ready;
    end

    // Stage 1 next state: capture sum, effective exponent, LZC and carry-path mantissa.
    always_comb begin
        e_eff      = (in_exp == {EXP_W{1'b0}}) ? EXP_ONE : in_exp;
        s1_sign_d  = s1_sign_q;
        s1_eeff_d  = s1_eeff_q;
        s1_carry_d = s1_carry_q;
        s1_m_d     = s1_m_q;
        s1_lzc_d   = s1_lzc_q;
        s1_mr_d    = s1_mr_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (in_xfer) begin
            s1_sign_d  = in_sign;
            s1_eeff_d  = e_eff;
            s1_carry_d = in_mant[MANT_W-1];
            s1_m_d     = in_mant[MANT_W-2:0];
            s1_lzc_d   = m_lzc;
            // right shift by one folds the dropped bit into sticky
            s1_mr_d    = {in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
        end else begin
            s1_sign_d  = s1_sign_q;
        end
    end

    // Stage 2 datapath: pick carry / zero / normal / denormal-clamp result.
    always_comb begin
        exp_inc       = {1'b0, s1_eeff_q} + EXP_ONE_X;
        eeff_x        = {1'b0, s1_eeff_q};
        lzc_x         = {{(EXP_W + 1 - LZC_W){1'b0}}, s1_lzc_q};
        // in the clamp case e_eff-1 < lzc, so it always fits the shift width
        clamp_sh      = LZC_W'(s1_eeff_q - EXP_ONE);
        res_pl.sign   = s1_sign_q;
        res_pl.exp    = {EXP_W{1'b0}};
        res_pl.mant   = {(MANT_W-1){1'b0}};
        res_zero      = 1'b0;
        res_ovf       = 1'b0;
        if (s1_carry_q) begin
            if (exp_inc >= EXP_MAX_X) begin
                res_pl.exp  = EXP_MAX;
                res_pl.mant = {(MANT_W-1){1'b0}};
                res_ovf     = 1'b1;
            end else begin
                res_pl.exp  = EXP_W'(exp_inc);
                res_pl.mant = s1_mr_q;
            end
        end else if (s1_m_q == {(MANT_W-1){1'b0}}) begin
            res_zero = 1'b1;
        end else if (lzc_x < eeff_x) begin
            res_pl.exp  = EXP_W'(eeff_x - lzc_x);
            res_pl.mant = s1_m_q << s1_lzc_q;
        end else begin
            res_pl.exp  = {EXP_W{1'b0}};
            res_pl.mant = s1_m_q << clamp_sh;
        end
    end

    // Stage 2 next state: load on advance, otherwise hold (payload stable under stall).
    always_comb begin
        if (s1_advance) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s1_advance) begin
            out_pl_d   = res_pl;
            out_zero_d = res_zero;
            out_ovf_d  = res_ovf;
        end else begin
            out_pl_d   = out_pl_q;
            out_zero_d = out_zero_q;
            out_ovf_d  = out_ovf_q;
        end
    end

    // Pipeline registers; reset discards any in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_eeff_q  <= {EXP_W{1'b0}};
            s1_carry_q <= 1'b0;
            s1_m_q     <= {(MANT_W-1){1'b0}};
            s1_lzc_q   <= {LZC_W{1'b0}};
            s1_mr_q    <= {(MANT_W-1){1'b0}};
            s2_valid_q <= 1'b0;
            out_pl_q   <= '{sign: 1'b0, exp: {EXP_W{1'b0}}, mant: {(MANT_W-1){1'b0}}};
            out_zero_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_eeff_q  <= s1_eeff_d;
            s1_carry_q <= s1_carry_d;
            s1_m_q     <= s1_m_d;
            s1_lzc_q   <= s1_lzc_d;
            s1_mr_q    <= s1_mr_d;
            s2_valid_q <= s2_valid_d;
            out_pl_q   <= out_pl_d;
            out_zero_q <= out_zero_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    // Output drive straight from stage 2 registers.
    always_comb begin
        out_valid = s2_valid_q;
        out_sign  = out_pl_q.sign;
        out_exp   = out_pl_q.exp;
        out_mant  = out_pl_q.mant;
        out_zero  = out_zero_q;
        out_ovf   = out_ovf_q;
    end

endmodule

// File: tb/tb_fp_mant_normalizer.sv
module tb_fp_mant_normalizer;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] mant;
        logic        zero;
        logic        ovf;
    } res_t;

    typedef struct {
        res_t res;
        int   age;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [26:0] out_mant;
    logic        out_zero;
    logic        out_ovf;

    int     n_assert = 0;
    int     n_fail   = 0;
    entry_t sb[$];

    fp_mant_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: normalization rules evaluated with plain integer arithmetic.
    function automatic res_t model(input logic s, input logic [7:0] e, input logic [27:0] m);
        res_t        r;
        int          ee;
        int          p;
        int          sh;
        logic [26:0] f;
        r    = '0;
        r.sign = s;
        ee   = (e == 8'd0) ? 1 : int'(e);
        f    = m[26:0];
        if (m[27]) begin
            if (ee + 1 >= 255) begin
                r.exp = 8'd255;
                r.ovf = 1'b1;
            end else begin
                r.exp  = 8'(ee + 1);
                r.mant = 27'(m >> 1) | {26'd0, m[0]};
            end
        end else if (f == 27'd0) begin
            r.zero = 1'b1;
        end else begin
            p = 26;
            while (!f[p]) p--;
            sh = 26 - p;
            if (sh < ee) begin
                r.mant = f << sh;
                r.exp  = 8'(ee - sh);
            end else begin
                r.mant = f << (ee - 1);
                r.exp  = 8'd0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, check against scoreboard, update scoreboard.
    // Called just after a falling edge; samples 3 time units later.
    task automatic cycle(input logic r, input logic v, input logic s, input logic [7:0] e,
                         input logic [27:0] m, input logic ordy, input bit use_d,
                         input res_t dexp, output bit acc);
        res_t   got;
        entry_t ne;
        rst = r; in_valid = v; in_sign = s; in_exp = e; in_mant = m; out_ready = ordy;
        acc = 1'b0;
        #3;
        got = '{sign: out_sign, exp: out_exp, mant: out_mant, zero: out_zero, ovf: out_ovf};
        if (r) begin
            sb.delete();
        end else begin
            chk("in_ready", 64'(in_ready), 64'((sb.size() < 2) || ordy));
            chk("out_valid", 64'(out_valid), 64'((sb.size() > 0) && (sb[0].age >= 2)));
            if (out_valid && sb.size() > 0) chk("payload", 64'(got), 64'(sb[0].res));
            if (out_valid && out_ready && sb.size() > 0) sb.pop_front();
            foreach (sb[i]) sb[i].age++;
            if (v && in_ready) begin
                ne.res = use_d ? dexp : model(s, e, m);
                ne.age = 1;
                sb.push_back(ne);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit          acc;
        res_t        nul;
        logic [27:0] rm;
        logic [7:0]  re;
        int          cyc;
        nul = '0;
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 28'd0; out_ready = 1'b0;

        // reset
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b0, nul, acc);
        cycle(1'b1, 1'b1, 1'b0, 8'd9, 28'h1234567, 1'b1, 1'b0, nul, acc);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_payload", 64'({out_sign, out_exp, out_mant, out_zero, out_ovf}), 64'd0);
        @(negedge clk);

        // directed cases from the plan, separated by idle cycles so latency is visible
        cycle(1'b0, 1'b1, 1'b0, 8'd127, 28'h8000000, 1'b1, 1'b1, '{1'b0, 8'd128, 27'h4000000, 1'b0, 1'b0}, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b1, 1'b0, nul, acc);
        cycle(1'b0, 1'b1, 1'b1, 8'd100, 28'h0100000, 1'b1, 1'b1, '{1'b1, 8'd94, 27'h4000000, 1'b0, 1'b0}, acc);
        cycle(1'b0, 1'b1, 1'b0, 8'd3, 28'h0000100, 1'b1, 1'b1, '{1'b0, 8'd0, 27'h0000400, 1'b0, 1'b0}, acc);
        cycle(1'b0, 1'b1, 1'b0, 8'd0, 28'h4000000, 1'b1, 1'b1, '{1'b0, 8'd1, 27'h4000000, 1'b0, 1'b0}, acc);
        cycle(1'b0, 1'b1, 1'b0, 8'd50, 28'h0000000, 1'b1, 1'b1, '{1'b0, 8'd0, 27'h0, 1'b1, 1'b0}, acc);
        cycle(1'b0, 1'b1, 1'b1, 8'd254, 28'h8000000, 1'b1, 1'b1, '{1'b1, 8'd255, 27'h0, 1'b0, 1'b1}, acc);
        cycle(1'b0, 1'b1, 1'b0, 8'd1, 28'h8000003, 1'b1, 1'b1, '{1'b0, 8'd2, 27'h4000001, 1'b0, 1'b0}, acc);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b1, 1'b0, nul, acc);

        // backpressure: 4 back-to-back inputs, out_ready low for the first 3 cycles
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            rm = 28'($urandom) >> $urandom_range(0, 27);
            re = 8'($urandom_range(0, 254));
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                cycle(1'b0, 1'b1, k[0], re, rm, (cyc >= 3), 1'b0, nul, acc);
                cyc++;
            end
            chk("bp_accept", 64'(acc), 64'd1);
        end
        for (int t = 0; t < 20 && sb.size() > 0; t++)
            cycle(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b1, 1'b0, nul, acc);
        chk("bp_drain", 64'(sb.size()), 64'd0);

        // randomized traffic with random backpressure
        for (int t = 0; t < 400; t++) begin
            rm = 28'($urandom) >> $urandom_range(0, 28);
            re = 8'($urandom_range(0, 254));
            if ($urandom_range(0, 7) == 0) re = 8'($urandom_range(0, 3));
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), re, rm,
                  1'($urandom_range(0, 3) != 0), 1'b0, nul, acc);
        end
        for (int t = 0; t < 20 && sb.size() > 0; t++)
            cycle(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b1, 1'b0, nul, acc);
        chk("rand_drain", 64'(sb.size()), 64'd0);

        // reset with both stages full
        cycle(1'b0, 1'b1, 1'b0, 8'd20, 28'h0800000, 1'b0, 1'b0, nul, acc);
        cycle(1'b0, 1'b1, 1'b1, 8'd30, 28'h0040000, 1'b0, 1'b0, nul, acc);
        cycle(1'b0, 1'b1, 1'b0, 8'd40, 28'h0020000, 1'b0, 1'b0, nul, acc);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b0, nul, acc);
        #3;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_payload", 64'({out_sign, out_exp, out_mant, out_zero, out_ovf}), 64'd0);
        @(negedge clk);
        for (int t = 0; t < 4; t++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 28'd0, 1'b1, 1'b0, nul, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
